// File: rtl/speech_framer.sv
// speech_framer: cuts a continuous sample stream into overlapping FRAME_LEN-sample frames for the FFT.
// Define PREEMPH_EN to apply first-order pre-emphasis (alpha = 15/16) on the write path.
module speech_framer #(
   parameter int unsigned SAMPLE_W  = 8,
   parameter int unsigned OUT_W     = 16,
   parameter int unsigned FRAME_LEN = 256,
   parameter int unsigned HOP       = 128,
   parameter int unsigned ADDR_W    = 9
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                stop,
   input  logic                s_valid,
   input  logic [SAMPLE_W-1:0] s_data,
   output logic                s_ready,
   output logic                f_valid,
   input  logic                f_ready,
   output logic [OUT_W-1:0]    f_data,
   output logic                f_first,
   output logic                f_last,
   output logic [7:0]          frame_idx,
   output logic                busy,
   output logic                overrun
);

   localparam int unsigned DEPTH  = 2 * FRAME_LEN;
   localparam int unsigned OCC_W  = ADDR_W + 1;
   localparam int unsigned BEAT_W = ADDR_W - 1;

   typedef enum logic [1:0] {StIdle, StLoad, StStream, StDone} state_e;

   state_e              r_state, w_state_nxt;
   logic [OUT_W-1:0]    r_mem [DEPTH];
   logic                r_busy, r_stopping, r_overrun;
   logic [ADDR_W-1:0]   r_wr_ptr, r_base, r_rd_ptr, w_rd_addr;
   logic [OCC_W-1:0]    r_occ, w_occ_nxt;
   logic [BEAT_W-1:0]   r_beat;
   logic [7:0]          r_frame_idx;
   logic [OUT_W-1:0]    r_f_data, w_proc;
   logic signed [OUT_W-1:0] w_x_ext;
   logic                w_s_ready, w_wr_fire, w_last, w_retire, w_rd_en, w_end;
   logic                w_stop_req, w_frame_ready, w_new_session;

   assign w_new_session = start && !r_busy;
   assign w_stop_req    = stop || r_stopping;
   assign w_s_ready     = r_busy && !r_stopping && (r_occ < OCC_W'(DEPTH));
   assign w_wr_fire     = s_valid && w_s_ready;
   assign w_frame_ready = r_busy && !w_stop_req && (r_occ >= OCC_W'(FRAME_LEN));
   assign w_last        = (r_beat == BEAT_W'(FRAME_LEN - 1));
   assign w_x_ext       = {{(OUT_W-SAMPLE_W){s_data[SAMPLE_W-1]}}, s_data};

`ifdef PREEMPH_EN
   logic [SAMPLE_W-1:0]     r_prev;
   logic signed [OUT_W-1:0] w_prev_ext;

   assign w_prev_ext = {{(OUT_W-SAMPLE_W){r_prev[SAMPLE_W-1]}}, r_prev};
   // x*16 - prev*15, with prev*15 formed as prev*16 - prev
   assign w_proc     = (w_x_ext <<< 4) - ((w_prev_ext <<< 4) - w_prev_ext);

   always_ff @(posedge clk) begin
      if (reset || w_new_session) begin
         r_prev <= '0;
      end else if (w_wr_fire) begin
         r_prev <= s_data;
      end
   end
`else
   assign w_proc = w_x_ext <<< 4;
`endif

   // Read FSM: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Read FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle:   if (w_frame_ready) w_state_nxt = StLoad;
         StLoad:   w_state_nxt = StStream;
         StStream: if (f_ready && w_last) w_state_nxt = StDone;
         StDone:   w_state_nxt = StIdle;
         default:  w_state_nxt = StIdle;
      endcase
   end

   // Read FSM: outputs; the next word is prefetched on every accepted beat
   always_comb begin
      f_valid  = 1'b0;
      f_first  = 1'b0;
      f_last   = 1'b0;
      w_rd_en  = 1'b0;
      w_retire = 1'b0;
      w_end    = 1'b0;
      case (r_state)
         StIdle:   w_end = r_busy && w_stop_req;
         StLoad:   w_rd_en = 1'b1;
         StStream: begin
            f_valid  = 1'b1;
            f_first  = (r_beat == '0);
            f_last   = w_last;
            w_rd_en  = f_ready && !w_last;
            w_retire = f_ready && w_last;
         end
         StDone:   w_end = r_busy && w_stop_req;
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy     <= 1'b0;
         r_stopping <= 1'b0;
         r_overrun  <= 1'b0;
      end else if (w_new_session) begin
         r_busy     <= 1'b1;
         r_stopping <= 1'b0;
         r_overrun  <= 1'b0;
      end else if (w_end) begin
         r_busy     <= 1'b0;
         r_stopping <= 1'b0;
      end else begin
         if (stop && r_busy) r_stopping <= 1'b1;
         if (r_busy && !r_stopping && s_valid && !w_s_ready) r_overrun <= 1'b1;
      end
   end

   always_comb begin
      w_occ_nxt = r_occ;
      if (w_wr_fire) w_occ_nxt = w_occ_nxt + OCC_W'(1);
      if (w_retire)  w_occ_nxt = w_occ_nxt - OCC_W'(HOP);
   end

   always_ff @(posedge clk) begin
      if (reset || w_new_session) begin
         r_wr_ptr    <= '0;
         r_base      <= '0;
         r_occ       <= '0;
         r_frame_idx <= '0;
      end else begin
         if (w_wr_fire) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         r_occ <= w_occ_nxt;
         if (w_retire) begin
            r_base      <= r_base + ADDR_W'(HOP);
            r_frame_idx <= r_frame_idx + 8'd1;
         end
      end
   end

   // occ <= DEPTH keeps the write pointer out of any pending or streaming frame
   always_ff @(posedge clk) begin
      if (w_wr_fire) r_mem[r_wr_ptr] <= w_proc;
   end

   assign w_rd_addr = (r_state == StLoad) ? r_base : r_rd_ptr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_f_data <= '0;
         r_rd_ptr <= '0;
         r_beat   <= '0;
      end else if (w_rd_en) begin
         r_f_data <= r_mem[w_rd_addr];
         r_rd_ptr <= w_rd_addr + ADDR_W'(1);
         r_beat   <= (r_state == StLoad) ? '0 : r_beat + BEAT_W'(1);
      end
   end

   assign s_ready   = w_s_ready;
   assign f_data    = r_f_data;
   assign frame_idx = r_frame_idx;
   assign busy      = r_busy;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_speech_framer.sv
// tb_speech_framer: directed bench for speech_framer; sample n carries value n mod 128.
// Inputs change on the falling edge, outputs are checked on the falling edge.
module tb_speech_framer;

   localparam int FRAME_LEN = 256;
   localparam int HOP       = 128;

   logic        clk, reset, start, stop;
   logic        s_valid, s_ready, f_valid, f_ready, f_first, f_last, busy, overrun;
   logic [7:0]  s_data, frame_idx;
   logic [15:0] f_data;

   int n_cmp   = 0;
   int n_bad   = 0;
   int n_wr    = 0;
   int n_beats = 0;

   speech_framer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .f_valid   (f_valid),
      .f_ready   (f_ready),
      .f_data    (f_data),
      .f_first   (f_first),
      .f_last    (f_last),
      .frame_idx (frame_idx),
      .busy      (busy),
      .overrun   (overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] exp_word(input int n);
      int x;
      x = n % 128;
`ifdef PREEMPH_EN
      begin
         int p;
         p = (n == 0) ? 0 : (n - 1) % 128;
         return 16'(16 * x - 15 * p);
      end
`else
      return 16'(16 * x);
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: score handshakes that the next rising edge will complete
   task automatic cycle();
      logic        held_pend;
      logic [25:0] held;
      held_pend = f_valid && !f_ready;
      held      = {f_first, f_last, frame_idx, f_data};
      if (f_valid && f_ready) begin
         int fr, b;
         fr = n_beats / FRAME_LEN;
         b  = n_beats % FRAME_LEN;
         chk("beat", 32'({f_first, f_last, frame_idx, f_data}),
             32'({b == 0, b == FRAME_LEN - 1, 8'(fr), exp_word(fr * HOP + b)}));
         n_beats++;
      end
      if (s_valid && s_ready) n_wr++;
      @(negedge clk);
      if (held_pend) begin
         chk("stall_hold", 32'({f_valid, f_first, f_last, frame_idx, f_data}), 32'({1'b1, held}));
      end
   endtask

   // mode 0: f_ready high, 1: f_ready low, 2: f_ready toggles every cycle
   task automatic run(input int wr_target, input int beat_target, input int mode,
                      input int max_cyc);
      int c;
      c = 0;
      while ((n_wr < wr_target || n_beats < beat_target) && c < max_cyc) begin
         s_valid = (n_wr < wr_target);
         s_data  = 8'(n_wr % 128);
         case (mode)
            0:       f_ready = 1'b1;
            1:       f_ready = 1'b0;
            default: f_ready = (c % 2 == 0);
         endcase
         cycle();
         c++;
      end
      s_valid = 1'b0;
      chk("run_budget", 32'(c < max_cyc), 32'd1);
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      stop    = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'd0;
      f_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", 32'({s_ready, f_valid, f_first, f_last, busy, overrun, frame_idx, f_data}),
          32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_busy", 32'({busy, s_ready}), 32'd0);

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_state", 32'({busy, s_ready, overrun, frame_idx}), 32'({3'b110, 8'd0}));

      // Frame 0: fill, then f_valid two cycles after occ reaches FRAME_LEN
      run(256, 0, 0, 1000);
      chk("fv_lat1", 32'(f_valid), 32'd0);
      @(negedge clk);
      chk("fv_lat2", 32'(f_valid), 32'd0);
      @(negedge clk);
      chk("fv_rise", 32'({f_valid, f_first}), 32'd3);
      run(256, 256, 0, 1000);

      // Fill to capacity with the FFT stalled, then provoke overrun
      run(640, 0, 1, 2000);
      chk("full_ready", 32'({s_ready, overrun}), 32'd0);
      s_valid = 1'b1;
      s_data  = 8'(640 % 128);
      @(negedge clk);
      s_valid = 1'b0;
      chk("overrun_set", 32'({overrun, s_ready}), 32'd2);
      chk("stalled_f1", 32'({f_valid, f_first, frame_idx, f_data}),
          32'({2'b11, 8'd1, exp_word(128)}));

      // Frame 1 intact after overrun; frame 2 with toggling f_ready
      run(640, 512, 0, 1000);
      run(640, 768, 2, 2000);

      // Stop in the middle of frame 3
      run(640, 868, 0, 1000);
      chk("ready_pre_stop", 32'(s_ready), 32'd1);
      stop = 1'b1;
      run(640, 869, 0, 10);
      stop = 1'b0;
      chk("stop_ready", 32'({s_ready, busy}), 32'd1);
      run(640, 1024, 0, 1000);
      chk("done_state", 32'({busy, f_valid, frame_idx}), 32'({2'b10, 8'd4}));
      @(negedge clk);
      chk("session_end", 32'({busy, s_ready, f_valid}), 32'd0);

      // Restart clears frame index and overrun
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart", 32'({busy, s_ready, overrun, frame_idx}), 32'({3'b110, 8'd0}));
      n_wr    = 0;
      n_beats = 0;
      run(256, 10, 0, 1000);

      // Reset in the middle of a streaming frame
      chk("pre_reset_fv", 32'(f_valid), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_reset", 32'({f_valid, busy, s_ready, frame_idx, f_data}), 32'd0);
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
